// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port memory arbiter: FSM state encodings and
// default geometry/timeout values.
package mem_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_TIMEOUT = 15;

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational 2-way round-robin picker: on a tie the requester that was not
// served last wins.
module mem_rr_pick (
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    output logic gnt_any,
    output logic gnt_id
);

    always_comb begin
        gnt_any = valid0 | valid1;
        gnt_id  = (valid0 && valid1) ? ~last : valid1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port between two
// requesters, with a saturating timeout that aborts a hung access.
//
//   state | meaning
//   IDLE  | arbitrate pending requests, latch the winner into m_*
//   BUSY  | memory request outstanding, timeout counter running
//   DONE  | ready/err pulse visible to the owner, no arbitration
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic                  valid0,
    input  logic                  valid1,
    input  logic                  wr_rd0,
    input  logic                  wr_rd1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0]      wdata0,
    input  logic [WIDTH-1:0]      wdata1,
    output logic [WIDTH-1:0]      rdata0,
    output logic [WIDTH-1:0]      rdata1,
    output logic                  ready0,
    output logic                  ready1,
    output logic                  err0,
    output logic                  err1,
    output logic                  m_valid,
    output logic                  m_wr_rd,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0]      m_wdata,
    input  logic [WIDTH-1:0]      m_rdata,
    input  logic                  m_ready,
    output logic                  busy
);

    localparam int             CW      = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(TIMEOUT);

    logic [1:0]            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
    logic                  m_valid_q, m_valid_d;
    logic                  m_wr_rd_q, m_wr_rd_d;
    logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
    logic [WIDTH-1:0]      m_wdata_q, m_wdata_d;
    logic [WIDTH-1:0]      rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                  ready0_q, ready0_d, ready1_q, ready1_d;
    logic                  err0_q, err0_d, err1_q, err1_d;
    logic                  busy_q, busy_d;
    logic                  gnt_any, gnt_id;

    mem_rr_pick u_pick (
        .valid0  (valid0),
        .valid1  (valid1),
        .last    (last_q),
        .gnt_any (gnt_any),
        .gnt_id  (gnt_id)
    );

    // Saturating so a stuck count can never wrap back under the limit.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (res) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_wr_rd_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            ready0_q  <= 1'b0;
            ready1_q  <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            m_valid_q <= m_valid_d;
            m_wr_rd_q <= m_wr_rd_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            ready0_q  <= ready0_d;
            ready1_q  <= ready1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_any) state_d = BUSY;
            BUSY:    if (m_ready || cnt_inc == CNT_MAX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d   = owner_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        m_valid_d = m_valid_q;
        m_wr_rd_d = m_wr_rd_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        ready0_d  = 1'b0;
        ready1_d  = 1'b0;
        err0_d    = 1'b0;
        err1_d    = 1'b0;
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    owner_d   = gnt_id;
                    cnt_d     = '0;
                    m_valid_d = 1'b1;
                    m_wr_rd_d = gnt_id ? wr_rd1 : wr_rd0;
                    m_addr_d  = gnt_id ? addr1  : addr0;
                    m_wdata_d = gnt_id ? wdata1 : wdata0;
                end
            end
            BUSY: begin
                cnt_d = cnt_inc;
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    last_d    = owner_q;
                    if (!m_wr_rd_q) begin
                        if (owner_q) rdata1_d = m_rdata;
                        else         rdata0_d = m_rdata;
                    end
                    if (owner_q) ready1_d = 1'b1;
                    else         ready0_d = 1'b1;
                end else if (cnt_inc == CNT_MAX) begin
                    m_valid_d = 1'b0;
                    last_d    = owner_q;
                    if (owner_q) begin
                        ready1_d = 1'b1;
                        err1_d   = 1'b1;
                    end else begin
                        ready0_d = 1'b1;
                        err0_d   = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign rdata0  = rdata0_q;
    assign rdata1  = rdata1_q;
    assign ready0  = ready0_q;
    assign ready1  = ready1_q;
    assign err0    = err0_q;
    assign err1    = err1_q;
    assign m_valid = m_valid_q;
    assign m_wr_rd = m_wr_rd_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign busy    = busy_q;

endmodule
